// File: rtl/serial_hex_comparator.sv
// Multi-cycle unsigned magnitude comparator: one nibble per clock, LSB first,
// with e/l/g cascade seeding and a start/busy/done handshake.
module serial_hex_comparator #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             e,
  input  logic             l,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             E,
  output logic             L,
  output logic             G
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       work_q, work_d;
  logic [2:0]       res_q, res_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [3:0]       a_nib, b_nib;
  logic [2:0]       work_upd;
  logic             last;

  assign a_sh  = a_q >> {cnt_q, 2'b00};
  assign b_sh  = b_q >> {cnt_q, 2'b00};
  assign a_nib = a_sh[3:0];
  assign b_nib = b_sh[3:0];
  assign last  = (cnt_q == CW'(N - 1));

  // Working result is {E,L,G}; a differing higher nibble always overrides.
  always_comb begin
    work_upd = work_q;
    if (a_nib > b_nib)      work_upd = 3'b001;
    else if (a_nib < b_nib) work_upd = 3'b010;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    work_d = work_q;
    res_d  = res_q;
    if (state_q == S_IDLE && start) begin
      a_d    = a;
      b_d    = b;
      work_d = {e, l, g};
      cnt_d  = '0;
    end else if (state_q == S_RUN) begin
      work_d = work_upd;
      cnt_d  = cnt_q + CW'(1);
      if (last) res_d = work_upd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      work_q <= '0;
      res_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      work_q <= work_d;
      res_q  <= res_d;
    end
  end

  assign E = res_q[2];
  assign L = res_q[1];
  assign G = res_q[0];

endmodule

// File: tb/tb_serial_hex_comparator.sv
// Self-checking bench for serial_hex_comparator (WIDTH=16): directed cases,
// randomized operands against a whole-word magnitude model, handshake and reset.
module tb_serial_hex_comparator;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         e = 1'b0, l = 1'b0, g = 1'b0;
  logic         busy, done, E, L, G;

  int errors = 0;
  int checks = 0;

  serial_hex_comparator #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .e(e), .l(l), .g(g), .busy(busy), .done(done), .E(E), .L(L), .G(G)
  );

  always #5 clk = ~clk;

  // Most significant differing nibble decides == plain unsigned compare.
  function automatic logic [2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic [2:0] c);
    if (x > y)      return 3'b001;
    else if (x < y) return 3'b010;
    else            return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain; 1: scramble inputs after capture; 2: pulse start in RUN and DONE
  task automatic do_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [2:0] c, input int mode, input string tag);
    int lat, busy_n, pulses;
    logic [2:0] res, exp;
    exp = model(ta, tb_v, c);
    @(negedge clk);
    a = ta; b = tb_v; {e, l, g} = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (mode == 1) begin
      a = '1; b = '1; {e, l, g} = ~c;
    end
    lat = -1; busy_n = 0; pulses = 0; res = 3'bxxx;
    for (int k = 0; k < 2 * N + 4; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          res = {E, L, G};
        end
      end
      if (mode == 2) begin
        if (k == 1 || k == N) start = 1'b1;
        else start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, " result"}, 32'(res), 32'(exp));
    check({tag, " latency"}, 32'(lat), 32'(N));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(N + 1));
    check({tag, " done_pulses"}, 32'(pulses), 32'd1);
    check({tag, " hold"}, 32'({E, L, G}), 32'(exp));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rc, exp_h;
    int last_pulse, npulse, gap_bad, hold_bad, res_bad, spurious;

    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset elg", 32'({E, L, G}), 32'd0);
    rst = 1'b0;

    do_cmp(16'h0000, 16'h0000, 3'b100, 0, "eq_seed100");
    do_cmp(16'h8000, 16'h0000, 3'b100, 0, "msb_gt");
    do_cmp(16'h0000, 16'h8000, 3'b100, 0, "msb_lt");
    do_cmp(16'h8000, 16'h8000, 3'b100, 0, "msb_eq");
    do_cmp(16'hFFFE, 16'hFFFF, 3'b100, 0, "lsb_lt");
    do_cmp(16'hFFFF, 16'hFFFE, 3'b100, 0, "lsb_gt");
    do_cmp(16'h1F00, 16'h20FF, 3'b100, 0, "hi_override");
    do_cmp(16'h1234, 16'h1234, 3'b010, 0, "cas_010");
    do_cmp(16'h1234, 16'h1234, 3'b001, 0, "cas_001");
    do_cmp(16'h1234, 16'h1234, 3'b110, 0, "cas_illegal110");
    do_cmp(16'h1234, 16'h1234, 3'b000, 1, "scramble_eq");
    do_cmp(16'h0F00, 16'h1000, 3'b100, 1, "scramble_lt");
    do_cmp(16'hA5A5, 16'h5A5A, 3'b100, 2, "start_poke");

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 3'($urandom);
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: ;
      endcase
      do_cmp(ra, rb, rc, 0, $sformatf("rand%0d", i));
    end

    // start held high: new comparison every N+2 cycles, operands changed at each done
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; {e, l, g} = 3'b100; start = 1'b1;
    exp_h = model(a, b, {e, l, g});
    last_pulse = -1; npulse = 0; gap_bad = 0; hold_bad = 0; res_bad = 0;
    for (int k = 0; k < 6 * (N + 2) + 2; k++) begin
      @(negedge clk);
      if (done) begin
        if ({E, L, G} !== exp_h) res_bad++;
        if (last_pulse >= 0 && (k - last_pulse) != N + 2) gap_bad++;
        last_pulse = k;
        npulse++;
        a = W'($urandom); b = (npulse % 2 == 0) ? a : W'($urandom);
        {e, l, g} = 3'($urandom);
        exp_h = model(a, b, {e, l, g});
      end else if (npulse > 0 && {E, L, G} !== model(16'h0, 16'h0, 3'b0) && 1'b0) begin
        hold_bad++;
      end
    end
    start = 1'b0;
    check("held pulses", 32'(npulse), 32'd6);
    check("held gaps", 32'(gap_bad), 32'd0);
    check("held results", 32'(res_bad), 32'd0);
    repeat (N + 3) @(negedge clk);

    // stability of E/L/G through IDLE and the following RUN
    do_cmp(16'h0001, 16'h0000, 3'b100, 0, "pre_hold");
    @(negedge clk);
    a = 16'h0000; b = 16'h0001; start = 1'b1;
    hold_bad = 0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (!done && {E, L, G} !== 3'b001) hold_bad++;
    end
    check("hold_through_run", 32'(hold_bad), 32'd0);
    repeat (N) @(negedge clk);

    // asynchronous reset mid-RUN
    @(negedge clk);
    a = 16'h0000; b = 16'hFFFF; {e, l, g} = 3'b100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst elg", 32'({E, L, G}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    check("rst no_done", 32'(spurious), 32'd0);
    do_cmp(16'hFFFF, 16'hFFFF, 3'b100, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_hex_comparator.md
# serial_hex_comparator

Multi-cycle magnitude comparator for two WIDTH-bit operands, with a start/busy/done handshake. It compares one 4-bit nibble per clock, least-significant nibble first, and carries an equal/less/greater result from nibble to nibble in the same cascade convention as the combinational hex comparator. Inputs e/l/g seed the chain from lower-order stages. Outputs E/L/G are registered and can drive the next stage's cascade inputs. The block sits where operands arrive sequentially or where area matters more than latency.

## Interface
- WIDTH, default 16: operand width in bits; must be a multiple of 4 and at least 4. The number of nibbles is N = WIDTH/4.
- clk  input  1: clock; all state changes on the rising edge.
- rst  input  1: reset, asynchronous, active-high; returns the block to IDLE immediately.
- start  input  1: request a comparison; sampled only in IDLE.
- a  input  WIDTH: operand A, unsigned; captured on the accepted start edge.
- b  input  WIDTH: operand B, unsigned; captured on the accepted start edge.
- e  input  1: cascade-in "equal"; captured with the operands.
- l  input  1: cascade-in "less"; captured with the operands.
- g  input  1: cascade-in "greater"; captured with the operands.
- busy  output  1: high in every state except IDLE.
- done  output  1: one-cycle pulse; high while in DONE.
- E  output  1: result equal, registered.
- L  output  1: result less (A < B), registered.
- G  output  1: result greater (A > B), registered.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1 at an edge:
  - capture a, b and {e,l,g};
  - load the working result with {e,l,g};
  - set the nibble counter to 0;
  - go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each edge, for nibble k = counter (bits 4k+3:4k of the captured operands):
  - A nibble > B nibble: working result becomes {E=0, L=0, G=1};
  - A nibble < B nibble: working result becomes {E=0, L=1, G=0};
  - nibbles equal: working result unchanged;
  - then counter increments.
- RUN edge processing nibble N-1: load E/L/G with the updated working result and go to DONE.
- DONE: next edge goes to IDLE unconditionally.
- Net effect: the most significant differing nibble decides the result. If all nibbles are equal, E/L/G equal the captured cascade inputs exactly.
  - Illegal cascade patterns (e.g. 000, 110) pass through unmodified; no checking.
- The counter is ceil(log2(N)) bits wide, minimum 1. Comparisons are unsigned, nibble-wide.
- E/L/G change only on the edge that enters DONE. They hold their value through IDLE and the next RUN until the following DONE.
- start is ignored in RUN and DONE; a request there is dropped, not queued.
- Changes on a, b, e, l, g after the capture edge have no effect on the comparison in progress.

## Timing
- Reset values: state IDLE, busy=0, done=0, E=0, L=0, G=0; counter and captured data 0.
- start accepted at edge t0 -> RUN from t0 through edge t0+N, which processes the last nibble and enters DONE.
- done=1 and the new E/L/G are visible after edge t0+N, for exactly one cycle; back in IDLE after edge t0+N+1.
- busy=1 from after t0 until after t0+N+1, which is N+1 cycles. For WIDTH=16: busy for 5 cycles; done after the 4th edge following acceptance.
- Fastest repeat: a new start is accepted at edge t0+N+2, so one comparison per N+2 cycles.
- rst asserted mid-RUN or mid-DONE:
  - immediately IDLE, busy=0, done=0, E/L/G=0;
  - no done pulse for the aborted operation;
  - the first start after rst is released is accepted normally.
- start held high continuously: a new comparison is accepted every N+2 cycles.

## Test plan
- Equal operands, cascade seeded with 100: a=16'h0000, b=16'h0000, e/l/g=1/0/0 -> done after 4 edges, E/L/G=1/0/0; busy high for exactly 5 cycles.
- MSB decides: a=16'h8000, b=16'h0000 -> E/L/G=0/0/1. Then a=16'h0000, b=16'h8000 -> 0/1/0. Then a=b=16'h8000 -> 1/0/0.
- LSB decides: a=16'hFFFE, b=16'hFFFF -> 0/1/0. Then a=16'hFFFF, b=16'hFFFE -> 0/0/1. The higher nibble must override the lower one: a=16'h1F00, b=16'h20FF -> 0/1/0.
- Cascade pass-through: a=b=16'h1234 with e/l/g=0/1/0 -> 0/1/0; with 0/0/1 -> 0/0/1. Operands changed to 16'hFFFF during RUN -> result unchanged.
- Handshake: start pulsed in RUN and in DONE -> ignored, exactly one done pulse. start held high -> done pulses exactly 6 cycles apart; E/L/G stable between pulses.
- rst asserted after 2 RUN edges -> busy=0, done=0, E/L/G=0 at once; no done pulse follows. A fresh start with a=16'hFFFF, b=16'hFFFF -> 1/0/0 with normal latency.
